branch_exec_unit: RTL and testbench

//  Consumer end of the branch queue. Accepts one ready branch/jump op per cycle and reads its operands from the PRF.

---
 rtl/branch_exec_unit_if.sv | 64 ++++++
 rtl/branch_exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_branch_exec_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_exec_unit_if.sv
// Branch unit bus bundle: issue port from the branch queue, PRF read port,
// and the CDB request/grant/broadcast port. The unit itself uses the slave
// modport. The queue/PRF/arbiter side uses the master modport.
interface branch_exec_unit_if #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
);
  logic              flush;

  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_op;
  logic [2:0]        issue_funct3;
  logic [XLEN-1:0]   issue_pc;
  logic [XLEN-1:0]   issue_imm;
  logic [PREG_W-1:0] issue_ps1;
  logic [PREG_W-1:0] issue_ps2;
  logic [PREG_W-1:0] issue_pd;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic              issue_pred_tk;
  logic [XLEN-1:0]   issue_pred_tgt;

  logic [PREG_W-1:0] prf_raddr1;
  logic [PREG_W-1:0] prf_raddr2;
  logic [XLEN-1:0]   prf_rdata1;
  logic [XLEN-1:0]   prf_rdata2;

  logic              cdb_req;
  logic              cdb_grant;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic [XLEN-1:0]   cdb_data;
  logic [ROB_W-1:0]  cdb_rob_idx;
  logic              cdb_mispred;
  logic              cdb_taken;
  logic [XLEN-1:0]   cdb_target;

  modport master (
    output flush,
    output issue_valid, issue_op, issue_funct3, issue_pc, issue_imm,
    output issue_ps1, issue_ps2, issue_pd, issue_rob_idx,
    output issue_pred_tk, issue_pred_tgt,
    input  issue_ready,
    input  prf_raddr1, prf_raddr2,
    output prf_rdata1, prf_rdata2,
    output cdb_grant,
    input  cdb_req, cdb_valid, cdb_pd, cdb_data, cdb_rob_idx,
    input  cdb_mispred, cdb_taken, cdb_target
  );

  modport slave (
    input  flush,
    input  issue_valid, issue_op, issue_funct3, issue_pc, issue_imm,
    input  issue_ps1, issue_ps2, issue_pd, issue_rob_idx,
    input  issue_pred_tk, issue_pred_tgt,
    output issue_ready,
    output prf_raddr1, prf_raddr2,
    input  prf_rdata1, prf_rdata2,
    input  cdb_grant,
    output cdb_req, cdb_valid, cdb_pd, cdb_data, cdb_rob_idx,
    output cdb_mispred, cdb_taken, cdb_target
  );
endinterface

// File: rtl/branch_exec_unit.sv
// Branch execution unit: S1 latches the issued op, reads the PRF and resolves
// direction/target/mispredict; S2 buffers the result until the CDB arbiter
// grants it.
//
// S2 state | meaning
// ---------+---------------------------------------------------
// S2_EMPTY | no result buffered, cdb_req low
// S2_HOLD  | result buffered, cdb_req high, outputs held stable
module branch_exec_unit #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input logic               clk,
  input logic               rst_n,
  branch_exec_unit_if.slave bus
);
  typedef enum logic {S2_EMPTY, S2_HOLD} s2_state_e;

  s2_state_e         s2_state_q, s2_state_d;
  logic              s2_load;
  logic              s2_valid;
  logic              s1_adv;
  logic              rdy_en;
  logic              issue_ready;

  logic              s1_valid;
  logic [1:0]        s1_op;
  logic [2:0]        s1_funct3;
  logic [XLEN-1:0]   s1_pc, s1_imm, s1_pred_tgt;
  logic [PREG_W-1:0] s1_ps1, s1_ps2, s1_pd;
  logic [ROB_W-1:0]  s1_rob_idx;
  logic              s1_pred_tk;

  logic              c_cond, c_taken, c_mispred;
  logic [XLEN-1:0]   c_link, c_tgt, c_next, c_data, c_jalr_sum;
  logic [PREG_W-1:0] c_pd;

  logic [PREG_W-1:0] s2_pd;
  logic [XLEN-1:0]   s2_data, s2_target;
  logic [ROB_W-1:0]  s2_rob_idx;
  logic              s2_mispred, s2_taken;

  assign s2_valid    = (s2_state_q == S2_HOLD);
  assign s1_adv      = !s2_valid || bus.cdb_grant;
  assign issue_ready = rdy_en && !bus.flush && (!s1_valid || s1_adv);

  // Hold issue_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // S1 register: accept a new op whenever the slot is free or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_funct3   <= '0;
      s1_pc       <= '0;
      s1_imm      <= '0;
      s1_ps1      <= '0;
      s1_ps2      <= '0;
      s1_pd       <= '0;
      s1_rob_idx  <= '0;
      s1_pred_tk  <= 1'b0;
      s1_pred_tgt <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (issue_ready) begin
      s1_valid <= bus.issue_valid;
      if (bus.issue_valid) begin
        s1_op       <= bus.issue_op;
        s1_funct3   <= bus.issue_funct3;
        s1_pc       <= bus.issue_pc;
        s1_imm      <= bus.issue_imm;
        s1_ps1      <= bus.issue_ps1;
        s1_ps2      <= bus.issue_ps2;
        s1_pd       <= bus.issue_pd;
        s1_rob_idx  <= bus.issue_rob_idx;
        s1_pred_tk  <= bus.issue_pred_tk;
        s1_pred_tgt <= bus.issue_pred_tgt;
      end
    end
  end

  // S1 resolve: direction, target, link value and mispredict from PRF data
  always_comb begin
    c_link     = s1_pc + XLEN'(4);
    c_jalr_sum = bus.prf_rdata1 + s1_imm;
    c_tgt      = s1_pc + s1_imm;
    c_taken    = 1'b0;
    c_pd       = '0;
    c_data     = '0;
    case (s1_funct3)
      3'b000:  c_cond = (bus.prf_rdata1 == bus.prf_rdata2);
      3'b001:  c_cond = (bus.prf_rdata1 != bus.prf_rdata2);
      3'b100:  c_cond = ($signed(bus.prf_rdata1) <  $signed(bus.prf_rdata2));
      3'b101:  c_cond = ($signed(bus.prf_rdata1) >= $signed(bus.prf_rdata2));
      3'b110:  c_cond = (bus.prf_rdata1 <  bus.prf_rdata2);
      3'b111:  c_cond = (bus.prf_rdata1 >= bus.prf_rdata2);
      default: c_cond = 1'b0;
    endcase
    case (s1_op)
      2'b00: c_taken = c_cond;
      2'b01: begin
        c_taken = 1'b1;
        c_pd    = s1_pd;
        c_data  = c_link;
      end
      2'b10: begin
        c_taken = 1'b1;
        c_tgt   = {c_jalr_sum[XLEN-1:1], 1'b0};
        c_pd    = s1_pd;
        c_data  = c_link;
      end
      default: c_taken = 1'b0;
    endcase
    c_next    = c_taken ? c_tgt : c_link;
    c_mispred = (c_taken != s1_pred_tk) || (c_taken && (c_tgt != s1_pred_tgt));
  end

  // S2 state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_state_q <= S2_EMPTY;
    else        s2_state_q <= s2_state_d;
  end

  // S2 next state: load from S1 when empty or when the held result is granted
  always_comb begin
    s2_state_d = s2_state_q;
    s2_load    = 1'b0;
    case (s2_state_q)
      S2_EMPTY: begin
        if (s1_valid) begin
          s2_state_d = S2_HOLD;
          s2_load    = 1'b1;
        end
      end
      S2_HOLD: begin
        if (bus.cdb_grant) begin
          s2_state_d = s1_valid ? S2_HOLD : S2_EMPTY;
          s2_load    = s1_valid;
        end
      end
      default: s2_state_d = S2_EMPTY;
    endcase
    if (bus.flush) begin
      s2_state_d = S2_EMPTY;
      s2_load    = 1'b0;
    end
  end

  // S2 result buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_pd      <= '0;
      s2_data    <= '0;
      s2_rob_idx <= '0;
      s2_mispred <= 1'b0;
      s2_taken   <= 1'b0;
      s2_target  <= '0;
    end else if (s2_load) begin
      s2_pd      <= c_pd;
      s2_data    <= c_data;
      s2_rob_idx <= s1_rob_idx;
      s2_mispred <= c_mispred;
      s2_taken   <= c_taken;
      s2_target  <= c_next;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.prf_raddr1  = s1_ps1;
  assign bus.prf_raddr2  = s1_ps2;
  assign bus.cdb_req     = s2_valid;
  assign bus.cdb_valid   = s2_valid && bus.cdb_grant && !bus.flush;
  assign bus.cdb_pd      = s2_pd;
  assign bus.cdb_data    = s2_data;
  assign bus.cdb_rob_idx = s2_rob_idx;
  assign bus.cdb_mispred = s2_mispred;
  assign bus.cdb_taken   = s2_taken;
  assign bus.cdb_target  = s2_target;
endmodule

// File: tb/tb_branch_exec_unit.sv
// Bench for branch_exec_unit: directed scenarios plus randomized traffic,
// checked against an in-order queue of results computed from the op
// semantics at acceptance time.
module tb_branch_exec_unit;
  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd;
    logic [4:0]  rob;
    logic        ptk;
    logic [31:0] ptgt;
  } op_t;

  typedef struct packed {
    logic [5:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob;
    logic        mis;
    logic        tk;
    logic [31:0] tgt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] prf [64];
  op_t         cur;
  res_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  branch_exec_unit_if bif ();

  branch_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  assign bif.issue_op       = cur.op;
  assign bif.issue_funct3   = cur.f3;
  assign bif.issue_pc       = cur.pc;
  assign bif.issue_imm      = cur.imm;
  assign bif.issue_ps1      = cur.ps1;
  assign bif.issue_ps2      = cur.ps2;
  assign bif.issue_pd       = cur.pd;
  assign bif.issue_rob_idx  = cur.rob;
  assign bif.issue_pred_tk  = cur.ptk;
  assign bif.issue_pred_tgt = cur.ptgt;
  assign bif.prf_rdata1     = prf[bif.prf_raddr1];
  assign bif.prf_rdata2     = prf[bif.prf_raddr2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result straight from the instruction semantics.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic [31:0] a, b, fall, sum;
    logic        cond;
    a    = prf[o.ps1];
    b    = prf[o.ps2];
    fall = o.pc + 32'd4;
    case (o.f3)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd4:    cond = ((a ^ 32'h8000_0000) <  (b ^ 32'h8000_0000));
      3'd5:    cond = ((a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000));
      3'd6:    cond = (a < b);
      3'd7:    cond = (a >= b);
      default: cond = 1'b0;
    endcase
    r.rob = o.rob;
    if (o.op == 2'd1 || o.op == 2'd2) begin
      r.tk   = 1'b1;
      r.pd   = o.pd;
      r.data = fall;
      sum    = (o.op == 2'd2) ? a + o.imm : o.pc + o.imm;
      r.tgt  = (o.op == 2'd2) ? (sum & 32'hFFFF_FFFE) : sum;
    end else begin
      r.tk   = (o.op == 2'd0) ? cond : 1'b0;
      r.pd   = '0;
      r.data = '0;
      r.tgt  = r.tk ? o.pc + o.imm : fall;
    end
    r.mis = (r.tk != o.ptk) || (r.tk && (r.tgt != o.ptgt));
    return r;
  endfunction

  function automatic op_t mk(input logic [1:0] op, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [5:0] ps1, input logic [5:0] ps2,
                             input logic [5:0] pd, input logic [4:0] rob,
                             input logic ptk, input logic [31:0] ptgt);
    op_t o;
    o.op = op; o.f3 = f3; o.pc = pc; o.imm = imm; o.ps1 = ps1; o.ps2 = ps2;
    o.pd = pd; o.rob = rob; o.ptk = ptk; o.ptgt = ptgt;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t  o;
    res_t r;
    o.op  = 2'($urandom_range(0, 3));
    o.f3  = 3'($urandom);
    o.pc  = {$urandom} & 32'hFFFF_FFFC;
    o.imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed(12'($urandom)));
    o.ps1 = 6'($urandom_range(0, 7));
    o.ps2 = 6'($urandom_range(0, 7));
    o.pd  = 6'($urandom);
    o.rob = 5'($urandom);
    o.ptk = 1'($urandom);
    o.ptgt = 32'($urandom);
    r = model(o);
    if ($urandom_range(0, 1) == 1) begin
      o.ptk  = r.tk;
      o.ptgt = r.tgt;
    end
    return o;
  endfunction

  // Scoreboard: retire broadcasts in order, squash on flush/reset, enqueue accepts
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bif.cdb_valid) begin
        if (exp_q.size() == 0) begin
          chk("cdb_unexpected", 64'(bif.cdb_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_pd",      64'(bif.cdb_pd),      64'(e.pd));
          chk("cdb_data",    64'(bif.cdb_data),    64'(e.data));
          chk("cdb_rob_idx", 64'(bif.cdb_rob_idx), 64'(e.rob));
          chk("cdb_taken",   64'(bif.cdb_taken),   64'(e.tk));
          chk("cdb_mispred", 64'(bif.cdb_mispred), 64'(e.mis));
          chk("cdb_target",  64'(bif.cdb_target),  64'(e.tgt));
        end
      end
      if (bif.flush) exp_q.delete();
      if (bif.issue_valid && bif.issue_ready) exp_q.push_back(model(cur));
    end
  end

  task automatic send(input op_t o);
    bit ok;
    ok = 1'b0;
    cur = o;
    bif.issue_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = bif.issue_ready;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bif.issue_valid = 1'b0;
  endtask

  task automatic run_dir(input string tag, input op_t o, input logic tk,
                         input logic [31:0] tgt, input logic mis,
                         input logic [5:0] pd, input logic [31:0] data);
    send(o);
    @(negedge clk);
    chk({tag, "_req_n1"}, 64'(bif.cdb_req), 64'd0);
    @(negedge clk);
    chk({tag, "_valid_n2"}, 64'(bif.cdb_valid), 64'd1);
    chk({tag, "_taken"},    64'(bif.cdb_taken), 64'(tk));
    chk({tag, "_target"},   64'(bif.cdb_target), 64'(tgt));
    chk({tag, "_mispred"},  64'(bif.cdb_mispred), 64'(mis));
    chk({tag, "_pd"},       64'(bif.cdb_pd), 64'(pd));
    chk({tag, "_data"},     64'(bif.cdb_data), 64'(data));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 64; i++) prf[i] = 32'd0;
    cur = '0;
    bif.issue_valid = 1'b0;
    bif.flush       = 1'b0;
    bif.cdb_grant   = 1'b0;

    // Power-on reset: everything low, ready comes up one edge after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bif.issue_ready), 64'd0);
    chk("rst_req",   64'(bif.cdb_req), 64'd0);
    chk("rst_raddr", 64'(bif.prf_raddr1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_early", 64'(bif.issue_ready), 64'd0);
    @(negedge clk);
    chk("rel_ready", 64'(bif.issue_ready), 64'd1);
    @(posedge clk); #1;

    // Directed resolution cases, grant tied high
    prf[1] = 32'd5;        prf[2] = 32'd5;
    prf[3] = 32'hFFFF_FFFF; prf[4] = 32'd1;
    prf[6] = 32'h0000_1001;
    bif.cdb_grant = 1'b1;
    run_dir("beq",  mk(2'd0, 3'd0, 32'h100, 32'h20, 6'd1, 6'd2, 6'd9, 5'd1, 1'b0, 32'h0),
            1'b1, 32'h120, 1'b1, 6'd0, 32'd0);
    run_dir("jalr", mk(2'd2, 3'd0, 32'h200, 32'h4, 6'd6, 6'd0, 6'd7, 5'd2, 1'b1, 32'h1004),
            1'b1, 32'h1004, 1'b0, 6'd7, 32'h204);
    run_dir("blt",  mk(2'd0, 3'd4, 32'h100, 32'h40, 6'd3, 6'd4, 6'd0, 5'd3, 1'b1, 32'h140),
            1'b1, 32'h140, 1'b0, 6'd0, 32'd0);
    run_dir("bltu", mk(2'd0, 3'd6, 32'h100, 32'h40, 6'd3, 6'd4, 6'd0, 5'd4, 1'b0, 32'h0),
            1'b0, 32'h104, 1'b0, 6'd0, 32'd0);
    run_dir("jal",  mk(2'd1, 3'd0, 32'hFFFF_FFFC, 32'h10, 6'd0, 6'd0, 6'd12, 5'd5, 1'b1, 32'h0),
            1'b1, 32'h0000_000C, 1'b1, 6'd12, 32'h0);
    run_dir("ill",  mk(2'd3, 3'd0, 32'h300, 32'h8, 6'd1, 6'd2, 6'd13, 5'd6, 1'b1, 32'h308),
            1'b0, 32'h304, 1'b1, 6'd0, 32'd0);

    // Back-pressure: grant low, three offers, only two fit
    bif.cdb_grant = 1'b0;
    acc = 0;
    bif.issue_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cur = rand_op();
      @(negedge clk);
      if (bif.issue_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_ready",   64'(bif.issue_ready), 64'd0);
    chk("bp_req",     64'(bif.cdb_req), 64'd1);
    bif.cdb_grant = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_drain_valid", 64'(bif.cdb_valid), 64'd1);
      @(posedge clk); #1;
      bif.issue_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_drain_done", 64'(bif.cdb_req), 64'd0);
    @(posedge clk); #1;

    // Flush with S1 and S2 full while granted
    bif.cdb_grant = 1'b0;
    send(rand_op());
    send(rand_op());
    bif.cdb_grant   = 1'b1;
    bif.flush       = 1'b1;
    bif.issue_valid = 1'b1;
    @(negedge clk);
    chk("flush_cdb_valid", 64'(bif.cdb_valid), 64'd0);
    chk("flush_ready",     64'(bif.issue_ready), 64'd0);
    @(posedge clk); #1;
    bif.flush = 1'b0;
    bif.issue_valid = 1'b0;
    @(negedge clk);
    chk("flush_req_after",   64'(bif.cdb_req), 64'd0);
    chk("flush_ready_after", 64'(bif.issue_ready), 64'd1);
    @(posedge clk); #1;

    // Reset mid-stream with both stages full
    bif.cdb_grant = 1'b0;
    send(rand_op());
    send(rand_op());
    rst_n = 1'b0;
    #2;
    chk("mrst_req",    64'(bif.cdb_req), 64'd0);
    chk("mrst_ready",  64'(bif.issue_ready), 64'd0);
    chk("mrst_target", 64'(bif.cdb_target), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bif.cdb_grant = 1'b1;
    @(negedge clk);
    chk("mrst_req_rel", 64'(bif.cdb_req), 64'd0);
    @(negedge clk);
    chk("mrst_ready_rel", 64'(bif.issue_ready), 64'd1);
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard
    for (int i = 1; i < 64; i++) prf[i] = $urandom;
    prf[2] = prf[1];
    prf[5] = prf[1];
    prf[3] = 32'h8000_0000;
    prf[4] = 32'h7FFF_FFFF;
    for (int c = 0; c < 3000; c++) begin
      cur             = rand_op();
      bif.issue_valid = ($urandom_range(0, 2) != 0);
      bif.cdb_grant   = ($urandom_range(0, 3) != 0);
      bif.flush       = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end

    // Drain
    bif.issue_valid = 1'b0;
    bif.flush       = 1'b0;
    bif.cdb_grant   = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || bif.cdb_req); c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_req",   64'(bif.cdb_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
